regfile_sb: RTL and testbench

//  Parametrised integer register file for the RISC-V pipeline, replacing the fixed 32x32 two-read-port file.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/regfile_sb_if.sv | 30 +++
 rtl/rf_scoreboard.sv | 49 ++++
 rtl/regfile_sb.sv | 93 +++++++++
 tb/tb_regfile_sb.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V integer-pipeline definitions: default widths, register-file
// init encodings and the register-file sequencer state type.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    // Register-file preload patterns applied after reset
    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bus of the integer register file: read ports,
// writeback, issue/flush for the scoreboard, and the ready indication.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic                ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
        output rd_data, rd_busy, ready
    );
endinterface

// File: rtl/rf_scoreboard.sv
// One busy bit per register for ID-stage hazard detection; issue sets,
// writeback clears, flush clears all. x0 is never busy.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a new producer supersedes a retiring one
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (flush) begin
                busy_d = '0;
            end else begin
                if (wr_en)  busy_d[wr_addr] = 1'b0;
                if (iss_en) busy_d[iss_rd]  = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_busy
        logic [AW-1:0] addr;
        assign addr = rd_addr[i*AW +: AW];
        // A same-cycle writeback releases the hazard without a bubble
        assign rd_busy[i] = run && busy_q[addr] && !(wr_en && wr_addr == addr)
                            && (addr != '0);
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file: NRD registered read ports with
// write-first bypass, one write port, post-reset preload and scoreboard.
module regfile_sb #(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int NREGS     = riscv_pkg::NREGS,
    parameter int NRD       = 2,
    parameter int INIT_MODE = riscv_pkg::INIT_ZERO
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    import riscv_pkg::*;

    localparam int            AW   = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            run;
    logic [XLEN-1:0] init_val;
    logic [XLEN-1:0] mem [NREGS];

    assign run       = rst_n && (state_q == RUN);
    assign bus.ready = (state_q == RUN);
    assign init_val  = (INIT_MODE == INIT_INDEX) ? XLEN'(idx_q) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // idx stops at the last register; RUN is left only through reset
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == INIT) begin
            if (idx_q == LAST) state_d = RUN;
            else               idx_d   = idx_q + AW'(1);
        end
    end

    // Storage is deliberately not reset; the init sequence preloads it
    always_ff @(posedge clk) begin
        if (rst_n && state_q == INIT)
            mem[idx_q] <= init_val;
        else if (run && bus.wr_en && bus.wr_addr != '0)
            mem[bus.wr_addr] <= bus.wr_data;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_q;

        assign addr = bus.rd_addr[i*AW +: AW];

        always_ff @(posedge clk) begin
            if (!run)
                data_q <= '0;
            else if (addr == '0)
                data_q <= '0;
            else if (bus.wr_en && bus.wr_addr == addr)
                data_q <= bus.wr_data;
            else
                data_q <= mem[addr];
        end

        assign bus.rd_data[i*XLEN +: XLEN] = data_q;
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .iss_en  (bus.iss_en),
        .iss_rd  (bus.iss_rd),
        .flush   (bus.flush),
        .rd_addr (bus.rd_addr),
        .rd_busy (bus.rd_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: an INIT_MODE=1 and an INIT_MODE=0 instance
// share the same stimulus; expected values are hand-computed constants.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus1 ();
    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus0 ();

    assign bus0.rd_addr = bus1.rd_addr;
    assign bus0.wr_en   = bus1.wr_en;
    assign bus0.wr_addr = bus1.wr_addr;
    assign bus0.wr_data = bus1.wr_data;
    assign bus0.iss_en  = bus1.iss_en;
    assign bus0.iss_rd  = bus1.iss_rd;
    assign bus0.flush   = bus1.flush;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .INIT_MODE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .INIT_MODE(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after reset release until ready, bounded
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus1.ready && n < 100);
    endtask

    task automatic idle();
        bus1.wr_en  = 1'b0;
        bus1.iss_en = 1'b0;
        bus1.flush  = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus1.rd_addr = '0;
        bus1.wr_addr = '0;
        bus1.wr_data = '0;
        bus1.iss_rd  = '0;
        idle();
        step();
        step();
        chk("rst_ready", 64'(bus1.ready), 64'd0);
        chk("rst_rd_data", 64'(bus1.rd_data), 64'd0);
        chk("rst_rd_busy", 64'(bus1.rd_busy), 64'd0);

        // T1: INIT with traffic that must be ignored
        rst_n        = 1'b1;
        bus1.rd_addr = {5'd31, 5'd5};
        bus1.iss_en  = 1'b1;
        bus1.iss_rd  = 5'd5;
        bus1.wr_en   = 1'b1;
        bus1.wr_addr = 5'd31;
        bus1.wr_data = 32'h0000_0BAD;
        wait_ready(cyc);
        chk("init_cycles", 64'(cyc), 64'd31);
        chk("init_rd_data_zero", 64'(bus1.rd_data), 64'd0);
        idle();
        #1;
        chk("init_iss_ignored", 64'(bus1.rd_busy), 64'd0);
        step();
        chk("init_mode1_x5_x31", 64'(bus1.rd_data), {32'd31, 32'd5});
        chk("init_mode0_x5_x31", 64'(bus0.rd_data), 64'd0);

        // T2: write then read; writes to x0 dropped
        bus1.wr_en   = 1'b1;
        bus1.wr_addr = 5'd7;
        bus1.wr_data = 32'hDEAD_BEEF;
        bus1.rd_addr = {5'd0, 5'd0};
        step();
        idle();
        bus1.rd_addr = {5'd0, 5'd7};
        step();
        chk("wr_rd_x7", 64'(bus1.rd_data), {32'd0, 32'hDEAD_BEEF});
        bus1.wr_en   = 1'b1;
        bus1.wr_addr = 5'd0;
        bus1.wr_data = 32'h0000_1234;
        bus1.rd_addr = {5'd0, 5'd0};
        step();
        chk("x0_bypass_zero", 64'(bus1.rd_data), 64'd0);
        idle();
        step();
        chk("x0_read_zero", 64'(bus1.rd_data), 64'd0);

        // T3: write-first bypass on both ports
        bus1.wr_en   = 1'b1;
        bus1.wr_addr = 5'd3;
        bus1.wr_data = 32'hA5A5_A5A5;
        bus1.rd_addr = {5'd3, 5'd3};
        step();
        chk("bypass_both", 64'(bus1.rd_data), {32'hA5A5_A5A5, 32'hA5A5_A5A5});
        idle();
        bus1.rd_addr = {5'd3, 5'd7};
        step();
        chk("stored_x3_x7", 64'(bus1.rd_data), {32'hA5A5_A5A5, 32'hDEAD_BEEF});

        // T4: scoreboard set, same-cycle release, set-wins
        bus1.iss_en  = 1'b1;
        bus1.iss_rd  = 5'd9;
        bus1.rd_addr = {5'd3, 5'd9};
        step();
        idle();
        #1;
        chk("busy_x9", 64'(bus1.rd_busy), 64'b01);
        bus1.wr_en   = 1'b1;
        bus1.wr_addr = 5'd9;
        bus1.wr_data = 32'h0000_0099;
        #1;
        chk("busy_x9_wb_release", 64'(bus1.rd_busy), 64'b00);
        step();
        idle();
        #1;
        chk("busy_x9_cleared", 64'(bus1.rd_busy), 64'b00);
        chk("x9_bypass", 64'(bus1.rd_data[31:0]), 64'h99);
        bus1.iss_en  = 1'b1;
        bus1.iss_rd  = 5'd9;
        bus1.wr_en   = 1'b1;
        bus1.wr_addr = 5'd9;
        bus1.wr_data = 32'h0000_0100;
        step();
        idle();
        #1;
        chk("iss_wb_set_wins", 64'(bus1.rd_busy), 64'b01);
        chk("x9_bypass2", 64'(bus1.rd_data[31:0]), 64'h100);

        // T5: flush clears everything including a same-cycle issue
        bus1.iss_en = 1'b1;
        bus1.iss_rd = 5'd4;
        step();
        bus1.iss_rd = 5'd5;
        step();
        bus1.iss_rd = 5'd6;
        step();
        idle();
        bus1.rd_addr = {5'd5, 5'd4};
        #1;
        chk("busy_x4_x5", 64'(bus1.rd_busy), 64'b11);
        bus1.rd_addr = {5'd9, 5'd6};
        #1;
        chk("busy_x6_x9", 64'(bus1.rd_busy), 64'b11);
        bus1.flush  = 1'b1;
        bus1.iss_en = 1'b1;
        bus1.iss_rd = 5'd7;
        step();
        idle();
        bus1.rd_addr = {5'd7, 5'd6};
        #1;
        chk("flush_x6_x7", 64'(bus1.rd_busy), 64'b00);
        bus1.rd_addr = {5'd9, 5'd4};
        #1;
        chk("flush_x4_x9", 64'(bus1.rd_busy), 64'b00);

        // T6: reset during RUN restarts INIT
        bus1.wr_en   = 1'b1;
        bus1.wr_addr = 5'd2;
        bus1.wr_data = 32'h0000_0055;
        step();
        idle();
        bus1.iss_en  = 1'b1;
        bus1.iss_rd  = 5'd2;
        step();
        idle();
        bus1.rd_addr = {5'd0, 5'd2};
        #1;
        chk("busy_x2", 64'(bus1.rd_busy), 64'b01);
        step();
        chk("x2_written", 64'(bus0.rd_data), {32'd0, 32'h55});
        rst_n = 1'b0;
        step();
        chk("rst2_ready", 64'({bus1.ready, bus0.ready}), 64'd0);
        chk("rst2_rd_data", 64'(bus1.rd_data), 64'd0);
        chk("rst2_rd_busy", 64'(bus1.rd_busy), 64'd0);
        rst_n = 1'b1;
        wait_ready(cyc);
        chk("reinit_cycles", 64'(cyc), 64'd31);
        chk("reinit_busy", 64'(bus1.rd_busy), 64'd0);
        step();
        chk("reinit_mode0_x2", 64'(bus0.rd_data), 64'd0);
        chk("reinit_mode1_x2", 64'(bus1.rd_data), {32'd0, 32'd2});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
